// File: rtl/conv_accum.sv
// -----------------------------------------------------------------------------
// conv_accum -- multiply-accumulate engine for one convolution window
//
// Accumulates TAPS signed pixel*weight products (for example a 3x3 kernel) and
// presents the sum on a valid/ready output. The kernel weights are written one
// per w_load strobe through an auto-incrementing pointer, but only while the
// block is idle.
//
// Parameters
//   TAPS       number of kernel taps accumulated per output (default 9)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   w_load     weight write strobe (honoured only in IDLE)
//   w_data     signed 32-bit weight written at the weight pointer
//   in_valid   input pixel valid
//   in_ready   block accepts a pixel this cycle (low while a result is held)
//   in_pixel   signed 32-bit feature-map pixel
//   out_valid  out_data holds a completed convolution result
//   out_ready  downstream accepts the result
//   out_data   signed 32-bit accumulated result, held between windows
//   busy       high while a window is being accumulated or its result held
//
// Build option
//   CONV_ACCUM_SAT_EN  when defined, every accumulation step is computed at
//                      full width and clamped to [-2^31, 2^31-1]. When not
//                      defined the sum wraps in two's complement.
// -----------------------------------------------------------------------------
module conv_accum #(
    parameter int TAPS = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        w_load,
    input  logic [31:0] w_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pixel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    // Tap counter / weight pointer width; kept at least one bit so TAPS=1
    // still elaborates.
    localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CW-1:0] LAST_TAP = CW'(TAPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [31:0]    acc_reg, acc_next;
    logic [31:0]    out_data_reg, out_data_next;
    logic [CW-1:0]  tap_cnt_reg, tap_cnt_next;
    logic [CW-1:0]  w_ptr_reg, w_ptr_next;
    logic [31:0]    weight_reg [TAPS];

    logic           transfer;
    logic           weight_we;
    logic [TAPS-1:0] weight_hit;
    logic [CW-1:0]  tap_sel;
    logic [31:0]    sel_weight;
    logic [31:0]    acc_base;
    logic [31:0]    step_sum;

    // -------------------------------------------------------------------------
    // Handshakes and weight-write qualification
    // -------------------------------------------------------------------------
    assign transfer  = in_valid && in_ready;
    // Weight writes are only honoured in IDLE; a strobe during ACC/HOLD is
    // dropped entirely, so neither the weights nor the pointer move.
    assign weight_we = w_load && (state_reg == IDLE);

    // One-hot decode of the weight pointer into per-register write enables.
    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_weight_hit
            assign weight_hit[gi] = weight_we && (w_ptr_reg == CW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                weight_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                if (weight_hit[i]) begin
                    weight_reg[i] <= w_data;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath: one accumulation step
    // -------------------------------------------------------------------------
    // The first pixel of a window always pairs with weight[0] and starts from
    // a zero base, so a stale tap_cnt/acc in IDLE never leaks into a window.
    assign tap_sel    = (state_reg == IDLE) ? '0 : tap_cnt_reg;
    assign sel_weight = weight_reg[tap_sel];
    assign acc_base   = (state_reg == IDLE) ? '0 : acc_reg;

`ifdef CONV_ACCUM_SAT_EN
    localparam logic signed [64:0] SAT_MAX = 65'sd2147483647;
    localparam logic signed [64:0] SAT_MIN = -65'sd2147483648;

    logic signed [63:0] product;
    logic signed [64:0] full_sum;

    // Full 64-bit product plus sign-extended accumulator: 65 bits cannot
    // overflow, so the clamp decision is exact.
    assign product  = 64'($signed(in_pixel)) * 64'($signed(sel_weight));
    assign full_sum = {{33{acc_base[31]}}, acc_base} + {product[63], product};

    always_comb begin
        step_sum = full_sum[31:0];
        if (full_sum > SAT_MAX) begin
            step_sum = 32'h7FFF_FFFF;
        end else if (full_sum < SAT_MIN) begin
            step_sum = 32'h8000_0000;
        end
    end
`else
    // With wrap-around arithmetic only the low half of the 64-bit product can
    // affect the 32-bit sum, and that half is the same for signed and unsigned
    // operands, so a 32-bit multiply is exact here.
    assign step_sum = acc_base + (in_pixel * sel_weight);
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            out_data_reg <= '0;
            tap_cnt_reg  <= '0;
            w_ptr_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            out_data_reg <= out_data_next;
            tap_cnt_reg  <= tap_cnt_next;
            w_ptr_reg    <= w_ptr_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        out_data_next = out_data_reg;
        tap_cnt_next  = tap_cnt_reg;
        w_ptr_next    = w_ptr_reg;

        if (weight_we) begin
            w_ptr_next = (w_ptr_reg == LAST_TAP) ? '0 : w_ptr_reg + CW'(1);
        end

        case (state_reg)
            IDLE: begin
                if (transfer) begin
                    acc_next = step_sum;
                    if (TAPS == 1) begin
                        // Single-tap kernel: the first pixel completes the window.
                        out_data_next = step_sum;
                        tap_cnt_next  = '0;
                        state_next    = HOLD;
                    end else begin
                        tap_cnt_next = CW'(1);
                        state_next   = ACC;
                    end
                end
            end

            ACC: begin
                // Without a transfer (a bubble) acc and tap_cnt simply hold.
                if (transfer) begin
                    acc_next = step_sum;
                    if (tap_cnt_reg == LAST_TAP) begin
                        out_data_next = step_sum;
                        tap_cnt_next  = '0;
                        state_next    = HOLD;
                    end else begin
                        tap_cnt_next = tap_cnt_reg + CW'(1);
                    end
                end
            end

            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready  = (state_reg != HOLD);
    assign out_valid = (state_reg == HOLD);
    assign busy      = (state_reg != IDLE);
    assign out_data  = out_data_reg;

endmodule

// File: tb/tb_conv_accum.sv
// -----------------------------------------------------------------------------
// tb_conv_accum -- self-checking bench for conv_accum
//
// Windows are streamed through the DUT; the expected result of each window is
// computed by a small arithmetic model as the pixels are driven and queued.
// A negedge monitor pops and compares whenever an output handshake occurs.
// Directed checks cover reset values, output latency, back-pressure, overflow,
// mid-window reset and weight-write blocking while busy.
// -----------------------------------------------------------------------------
module tb_conv_accum;

    localparam int TAPS = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_load;
    logic [31:0] w_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pixel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_w [TAPS];
    int          model_ptr;
    logic [31:0] px [TAPS];
    logic [31:0] wt [TAPS];
    int          first_wait;

    conv_accum #(.TAPS(TAPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .w_load    (w_load),
        .w_data    (w_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // One accumulation step of the reference arithmetic.
    function automatic logic [31:0] step(input logic [31:0] a, input logic [31:0] p,
                                         input logic [31:0] w);
        longint s;
        s = longint'($signed(a)) + longint'($signed(p)) * longint'($signed(w));
`ifdef CONV_ACCUM_SAT_EN
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    // Output scoreboard: compare on every output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_output", {31'b0, out_valid}, 32'd0);
            end else begin
                check_val("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic load_weights(input logic [31:0] w [TAPS]);
        for (int i = 0; i < TAPS; i++) begin
            w_load = 1'b1;
            w_data = w[i];
            model_w[model_ptr] = w[i];
            model_ptr = (model_ptr + 1) % TAPS;
            @(posedge clk); #1;
        end
        w_load = 1'b0;
    endtask

    // Stream the first n pixels of a window. gap_max adds random bubbles;
    // wl_at >= 0 raises w_load (data 0x55) from that pixel to the window end.
    task automatic send_window(input logic [31:0] p [TAPS], input int n, input int gap_max,
                               input int wl_at, output int wait0);
        logic [31:0] acc;
        int          cnt;
        acc   = '0;
        wait0 = 0;
        for (int i = 0; i < n; i++) begin
            if (i == wl_at) begin
                w_load = 1'b1;
                w_data = 32'h55;
            end
            in_valid = 1'b0;
            repeat ($urandom_range(gap_max, 0)) begin
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_pixel = p[i];
            acc = step(acc, p[i], model_w[i]);
            if (i == TAPS - 1) exp_q.push_back(acc);
            cnt = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                cnt++;
                if (cnt > 100) begin
                    check_val("in_ready_timeout", {31'b0, in_ready}, 32'd1);
                    break;
                end
            end
            if (i == 0) wait0 = cnt;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        w_load   = 1'b0;
    endtask

    // Wait (bounded) until every queued result has been observed.
    task automatic drain();
        int cnt;
        cnt = 0;
        while (exp_q.size() > 0 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check_val("drain_queue_empty", exp_q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; w_load = 1'b0; w_data = '0; in_valid = 1'b0; in_pixel = '0;
        out_ready = 1'b1;
        model_ptr = 0;
        for (int i = 0; i < TAPS; i++) model_w[i] = '0;

        // ---- reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_val("rst_busy", {31'b0, busy}, 32'd0);
        check_val("rst_out_data", out_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // ---- unit weights, pixels 1..9 -> 45, one-cycle latency/valid
        for (int i = 0; i < TAPS; i++) begin wt[i] = 32'd1; px[i] = 32'(i + 1); end
        load_weights(wt);
        send_window(px, TAPS, 0, -1, first_wait);
        check_val("lat_out_valid", {31'b0, out_valid}, 32'd1);
        check_val("lat_out_data", out_data, 32'd45);
        @(posedge clk); #1;
        check_val("valid_one_cycle", {31'b0, out_valid}, 32'd0);
        check_val("idle_busy", {31'b0, busy}, 32'd0);

        // ---- centre weight 3, pixels 10..90 with random bubbles -> 150
        for (int i = 0; i < TAPS; i++) begin
            wt[i] = (i == 4) ? 32'd3 : 32'd0;
            px[i] = 32'(10 * (i + 1));
        end
        load_weights(wt);
        send_window(px, TAPS, 3, -1, first_wait);
        drain();
        check_val("centre_tap_150", out_data, 32'd150);

        // ---- back-pressure: 5 cycles stalled in HOLD
        for (int i = 0; i < TAPS; i++) px[i] = 32'(i + 1);
        out_ready = 1'b0;
        send_window(px, TAPS, 0, -1, first_wait);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_val("stall_out_valid", {31'b0, out_valid}, 32'd1);
            check_val("stall_in_ready", {31'b0, in_ready}, 32'd0);
            check_val("stall_out_data", out_data, 32'd15);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < TAPS; i++) px[i] = 32'(100 * (i + 1));
        send_window(px, TAPS, 0, -1, first_wait);
        check_val("next_first_wait", 32'(first_wait), 32'd1);
        drain();
        check_val("after_stall_1500", out_data, 32'd1500);

        // ---- overflow: weights 2, pixels 0x7FFFFFFF
        for (int i = 0; i < TAPS; i++) begin wt[i] = 32'd2; px[i] = 32'h7FFF_FFFF; end
        load_weights(wt);
        send_window(px, TAPS, 1, -1, first_wait);
        drain();
`ifdef CONV_ACCUM_SAT_EN
        check_val("overflow_sat", out_data, 32'h7FFF_FFFF);
`else
        check_val("overflow_wrap", out_data, 32'hFFFF_FFEE);
`endif

        // ---- reset after 4 pixels of a window
        for (int i = 0; i < TAPS; i++) begin wt[i] = 32'd1; px[i] = 32'd1; end
        load_weights(wt);
        send_window(px, 4, 0, -1, first_wait);
        rst = 1'b1;
        #1;
        check_val("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check_val("midrst_busy", {31'b0, busy}, 32'd0);
        check_val("midrst_out_data", out_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_ptr = 0;
        for (int i = 0; i < TAPS; i++) model_w[i] = '0;
        @(negedge clk);
        check_val("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < TAPS; i++) px[i] = 32'(i + 7);
        send_window(px, TAPS, 0, -1, first_wait);
        drain();
        check_val("weights_cleared", out_data, 32'd0);
        for (int i = 0; i < TAPS; i++) px[i] = 32'd1;
        load_weights(wt);
        send_window(px, TAPS, 2, -1, first_wait);
        drain();
        check_val("reload_ones_9", out_data, 32'd9);

        // ---- w_load during ACC is ignored (weights and pointer unchanged)
        for (int i = 0; i < TAPS; i++) begin wt[i] = 32'(i + 1); px[i] = 32'd1; end
        load_weights(wt);
        send_window(px, TAPS, 2, 3, first_wait);
        drain();
        check_val("wload_busy_45", out_data, 32'd45);
        for (int i = 0; i < TAPS; i++) begin wt[i] = (i == 0) ? 32'd4 : 32'd0; px[i] = 32'(i + 1); end
        load_weights(wt);
        send_window(px, TAPS, 0, -1, first_wait);
        drain();
        check_val("wptr_unchanged", out_data, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/conv_accum.md
CONV_ACCUM -- requirements
Module: conv_accum

Interface
REQ-001 Parameter: TAPS, 9, number of kernel taps accumulated per output (window size, e.g. 3x3).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: w_load  input  1  weight write strobe.
REQ-005 Port: w_data  input  32  signed weight value written on w_load.
REQ-006 Port: in_valid  input  1  window pixel valid.
REQ-007 Port: in_ready  output  1  block accepts a pixel this cycle.
REQ-008 Port: in_pixel  input  32  signed input feature-map pixel.
REQ-009 Port: out_valid  output  1  out_data holds a completed convolution result.
REQ-010 Port: out_ready  input  1  downstream (pool/activation stage) accepts result.
REQ-011 Port: out_data  output  32  signed accumulated result.
REQ-012 Port: busy  output  1  high in states ACC and HOLD.

Function
REQ-013 The block SHALL hold TAPS signed 32-bit weight registers and a write pointer w_ptr.
REQ-014 In IDLE, a cycle with w_load=1 SHALL write w_data to weight[w_ptr] and increment w_ptr, wrapping from TAPS-1 to 0.
REQ-015 w_load SHALL be ignored in ACC and HOLD; weights and w_ptr unchanged.
REQ-016 States: IDLE, ACC, HOLD; a pixel transfer occurs when in_valid and in_ready are both 1.
REQ-017 in_ready SHALL be 1 in IDLE and ACC, 0 in HOLD.
REQ-018 IDLE: on a transfer, acc <= term(pixel, weight[0]), tap_cnt <= 1, go to ACC (if TAPS=1, go directly to HOLD).
REQ-019 ACC: on a transfer, acc <= acc + term(pixel, weight[tap_cnt]), tap_cnt increments; the transfer at tap_cnt=TAPS-1 SHALL load the final sum into out_data and go to HOLD.
REQ-020 ACC with in_valid=0 SHALL hold acc and tap_cnt (bubbles allowed, no timeout).
REQ-021 HOLD: out_valid=1 and out_data stable until out_valid and out_ready both 1; then out_valid drops next cycle and state returns to IDLE.
REQ-022 Latency: out_valid SHALL assert the cycle after the last pixel is accepted; the next window's first pixel is accepted no earlier than the cycle after the output handshake.
REQ-023 out_data SHALL hold its last value outside HOLD.
REQ-024 term(p,w) SHALL be the full 64-bit signed product p*w; the default sum is the low 32 bits of acc + product (two's-complement wrap).
REQ-025 w_load while busy in the same cycle as a transfer SHALL be dropped with no side effect.

Reset
REQ-026 On rst=1 the block SHALL immediately enter IDLE with acc=0, tap_cnt=0, w_ptr=0, all weights=0, out_data=0, out_valid=0, busy=0, and in_ready=1 once rst deasserts.
REQ-027 Reset mid-window SHALL discard the partial sum; no output is produced for that window.

Configuration
REQ-028 Macro CONV_ACCUM_SAT_EN defined: each accumulation step SHALL saturate to [-2^31, 2^31-1], computed at full width before clamping.
REQ-029 Macro CONV_ACCUM_SAT_EN undefined: wrap arithmetic per REQ-024; no saturation logic instantiated.

Verification
REQ-030 Load 9 weights of 1, stream pixels 1..9 with out_ready=1 -> out_data=45, out_valid for one cycle, 1 cycle after the 9th pixel.
REQ-031 Load weight[4]=3 and others 0, stream pixels 10..90 step 10 with random in_valid gaps -> out_data=150.
REQ-032 Hold out_ready=0 for 5 cycles in HOLD -> out_data and out_valid stable and in_ready=0 throughout; the first pixel of the next window is accepted the cycle after the handshake.
REQ-033 All weights 2, all pixels 0x7FFFFFFF -> 0xFFFFFFEE without CONV_ACCUM_SAT_EN, 0x7FFFFFFF with it.
REQ-034 Assert rst after 4 pixels of a window -> out_valid=0, weights=0; reload weights of 1 and stream 9 pixels of 1 -> out_data=9.
REQ-035 Pulse w_load with 0x55 during ACC -> no weight changes; the result equals that of the unmodified weight set.
